// File: rtl/spi_slave_duplex.sv
// spi_slave_duplex
//   Full-duplex SPI slave with parametrised word width, SPI mode and bit order.
//   Receives words from an external SPI master and presents them to the system
//   clock domain. Transmits words handed over through a one-entry holding
//   register; an idle pattern is sent when nothing is pending.
//
// Ports
//   clk, reset            system clock (>= 4x spi_clk), async active-high reset
//   spi_clk, spi_cs_n,    SPI bus inputs from the master (asynchronous)
//   spi_mosi
//   spi_miso, spi_miso_oe slave data out and its output enable (CS asserted)
//   tx_data/valid/ready   load handshake into the tx holding register
//   tx_underrun           pulse: a word was loaded with no pending tx word
//   rx_data/valid/first   received word, update pulse, first-word-of-frame flag
//   rx_abort              pulse: CS released part way through a word
module spi_slave_duplex #(
   parameter int               WIDTH    = 32,
   parameter int               CPOL     = 0,
   parameter int               CPHA     = 0,
   parameter int               LSBFIRST = 0,
   parameter logic [WIDTH-1:0] TX_IDLE  = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spi_clk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             rx_first,
   output logic             rx_abort
);

   localparam int   CW        = $clog2(WIDTH + 1);
   localparam logic SCLK_IDLE = (CPOL != 0);

   // Synchronisers: [0] first flop, [1] synchronised level, [2] edge-detect history
   logic [2:0] sclk_sync_q;
   logic [2:0] cs_sync_q;
   logic [1:0] mosi_sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync_q <= {3{SCLK_IDLE}};
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
         cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      end
   end

   logic sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic cs_fall, cs_rise, cs_act;
   logic sample_ev, shift_ev, last_bit, load, advance;
   logic [WIDTH-1:0] rx_word, tx_shifted;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_first_q, rx_first_d;
   logic             rx_abort_q, rx_abort_d;
   logic             first_q, first_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             tx_underrun_q, tx_underrun_d;

   always_comb begin
      sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
      sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
      // Leading edge leaves the idle level, trailing edge returns to it
      lead_edge  = (CPOL == 0) ? sclk_rise : sclk_fall;
      trail_edge = (CPOL == 0) ? sclk_fall : sclk_rise;
      cs_fall    = ~cs_sync_q[1] & cs_sync_q[2];
      cs_rise    = cs_sync_q[1] & ~cs_sync_q[2];
      // Qualify on the delayed CS level so a last sample edge that coincides
      // with the CS rise still completes its word instead of aborting it.
      cs_act     = ~cs_sync_q[2];
      sample_ev  = cs_act & ((CPHA == 0) ? lead_edge : trail_edge);
      shift_ev   = cs_act & ((CPHA == 0) ? trail_edge : lead_edge);
      last_bit   = sample_ev && (cnt_q == CW'(WIDTH - 1));
      rx_word    = (LSBFIRST != 0) ? {mosi_sync_q[1], rx_sh_q[WIDTH-1:1]}
                                   : {rx_sh_q[WIDTH-2:0], mosi_sync_q[1]};
      tx_shifted = (LSBFIRST != 0) ? {1'b1, tx_sh_q[WIDTH-1:1]}
                                   : {tx_sh_q[WIDTH-2:0], 1'b1};
      if (CPHA == 0) begin
         load    = cs_fall | (last_bit & ~cs_sync_q[1]);
         // The trailing edge right after a completed word must not advance:
         // the next word's first bit is already on MISO.
         advance = shift_ev & (cnt_q != '0);
      end else begin
         load    = shift_ev & (cnt_q == '0) & ~cs_sync_q[1];
         advance = shift_ev & ~load;
      end
   end

   always_comb begin
      cnt_d         = cnt_q;
      rx_sh_d       = rx_sh_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      rx_first_d    = 1'b0;
      rx_abort_d    = 1'b0;
      first_d       = first_q;
      tx_sh_d       = tx_sh_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      tx_underrun_d = 1'b0;

      if (sample_ev) begin
         rx_sh_d = rx_word;
         if (last_bit) begin
            cnt_d      = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_word;
            rx_first_d = first_q;
            first_d    = 1'b0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (cs_rise && !last_bit && (cnt_q != '0))
         rx_abort_d = 1'b1;
      if (cs_sync_q[1])
         cnt_d = '0;
      if (cs_fall) begin
         first_d = 1'b1;
         cnt_d   = '0;
      end

      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if (load) begin
         if (hold_full_q) begin
            tx_sh_d     = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_sh_d       = TX_IDLE;
            tx_underrun_d = 1'b1;
         end
      end else if (advance) begin
         tx_sh_d = tx_shifted;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         rx_sh_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_first_q    <= 1'b0;
         rx_abort_q    <= 1'b0;
         first_q       <= 1'b0;
         tx_sh_q       <= TX_IDLE;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         rx_sh_q       <= rx_sh_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         rx_first_q    <= rx_first_d;
         rx_abort_q    <= rx_abort_d;
         first_q       <= first_d;
         tx_sh_q       <= tx_sh_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         tx_underrun_q <= tx_underrun_d;
      end
   end

   assign spi_miso    = (LSBFIRST != 0) ? tx_sh_q[0] : tx_sh_q[WIDTH-1];
   assign spi_miso_oe = ~cs_sync_q[1];
   assign tx_ready    = ~hold_full_q;
   assign tx_underrun = tx_underrun_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_first    = rx_first_q;
   assign rx_abort    = rx_abort_q;

endmodule
